// File: rtl/freq_div_prog_pkg.sv
// Shared definitions for the programmable multi-channel clock-enable generator.
package freq_div_prog_pkg;

    // Per-channel FSM encoding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_t;

    // Number of bits needed to represent the value n itself (minimum 1).
    function automatic int unsigned bits_required(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned b = 1; b < 32; b++) begin
            if ((n >> b) != 0) begin
                r = b + 1;
            end
        end
        return r;
    endfunction

    // High-time loaded at reset: half the default divisor, rounded down.
    function automatic int unsigned default_high(input int unsigned div);
        return div >> 1;
    endfunction

endpackage

// File: rtl/freq_div_chan.sv
// One divider channel: FSM, period counter, active/shadow settings, out/tick flops.
module freq_div_chan
    import freq_div_prog_pkg::*;
#(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_sync_start,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wr_div,
    input  logic [DIV_W-1:0] i_wr_high,
    output logic             o_out,
    output logic             o_tick,
    output logic             o_upd_pend
);

    localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] RST_HIGH = DIV_W'(default_high(DEFAULT_DIV));

    chan_state_t      r_state;
    chan_state_t      w_state_nxt;

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_high_act;
    logic [DIV_W-1:0] r_div_sh;
    logic [DIV_W-1:0] r_high_sh;
    logic             r_upd_pend;
    logic             r_out;
    logic             r_tick;

    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_high_nxt;
    logic             w_pend_nxt;
    logic             w_out_nxt;
    logic             w_tick_nxt;
    logic             w_start;

    logic [DIV_W-1:0] w_cnt_inc;
    logic [DIV_W-1:0] w_div_new;
    logic [DIV_W-1:0] w_high_new;
    logic             w_last;

    // Settings a period start would adopt, and the natural end-of-period condition.
    assign w_cnt_inc  = r_cnt + DIV_W'(1);
    assign w_div_new  = r_upd_pend ? r_div_sh  : r_div_act;
    assign w_high_new = r_upd_pend ? r_high_sh : r_high_act;
    assign w_last     = (r_div_act <= DIV_W'(1)) || (r_cnt == (r_div_act - DIV_W'(1)));

    // Next-state, counter and output decode; a start with divisor 0 parks the channel in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div_act;
        w_high_nxt  = r_high_act;
        w_pend_nxt  = r_upd_pend;
        w_out_nxt   = 1'b0;
        w_tick_nxt  = 1'b0;
        w_start     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (i_en) begin
                    w_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (!i_en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (i_sync_start || w_last) begin
                    w_start = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_out_nxt = (w_cnt_inc < r_high_act);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_start) begin
            w_div_nxt  = w_div_new;
            w_high_nxt = w_high_new;
            w_pend_nxt = 1'b0;
            w_cnt_nxt  = '0;
            if (w_div_new == '0) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = ST_RUN;
                w_tick_nxt  = 1'b1;
                w_out_nxt   = (w_high_new != '0);
            end
        end

        // A write on a start edge re-arms the pending flag for the following boundary.
        if (i_wr) begin
            w_pend_nxt = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter, active settings and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_div_act  <= RST_DIV;
            r_high_act <= RST_HIGH;
            r_upd_pend <= 1'b0;
            r_out      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_div_act  <= w_div_nxt;
            r_high_act <= w_high_nxt;
            r_upd_pend <= w_pend_nxt;
            r_out      <= w_out_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    // Shadow settings capture; last write before the boundary wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_sh  <= '0;
            r_high_sh <= '0;
        end else if (i_wr) begin
            r_div_sh  <= i_wr_div;
            r_high_sh <= i_wr_high;
        end
    end

    assign o_out      = r_out;
    assign o_tick     = r_tick;
    assign o_upd_pend = r_upd_pend;

endmodule

// File: rtl/freq_div_prog.sv
// Multi-channel programmable divider: write decode, sync fan-out, channel array.
module freq_div_prog
    import freq_div_prog_pkg::*;
#(
    parameter  int unsigned NCH         = 4,
    parameter  int unsigned DIV_W       = 8,
    parameter  int unsigned DEFAULT_DIV = 32,
    localparam int unsigned CH_W        = bits_required(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic             sync_start,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] wr_high,
    output logic [NCH-1:0]   out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   upd_pend
);

    logic [NCH-1:0] w_wr_sel;

    // One channel per index; out-of-range wr_ch matches no channel and is dropped.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        assign w_wr_sel[gi] = wr_en && (wr_ch == CH_W'(gi));

        freq_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .i_en         (en[gi]),
            .i_sync_start (sync_start),
            .i_wr         (w_wr_sel[gi]),
            .i_wr_div     (wr_div),
            .i_wr_high    (wr_high),
            .o_out        (out[gi]),
            .o_tick       (tick[gi]),
            .o_upd_pend   (upd_pend[gi])
        );
    end

endmodule

// File: tb/tb_freq_div_prog.sv
// Scoreboard bench for freq_div_prog with two channels, 8-bit fields, default divisor 32.
module tb_freq_div_prog;
    import freq_div_prog_pkg::*;

    localparam int unsigned NCH   = 2;
    localparam int unsigned DIV_W = 8;
    localparam int unsigned DEF   = 32;
    localparam int unsigned CH_W  = bits_required(NCH);

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   en;
    logic             sync_start;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [DIV_W-1:0] wr_div;
    logic [DIV_W-1:0] wr_high;
    logic [NCH-1:0]   out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   upd_pend;

    freq_div_prog #(
        .NCH         (NCH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .sync_start (sync_start),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_div     (wr_div),
        .wr_high    (wr_high),
        .out        (out),
        .tick       (tick),
        .upd_pend   (upd_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] out;
        logic [1:0] tick;
        logic [1:0] pend;
        int         tag;
        int         idx;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   cyc_idx = 0;

    // Expected-waveform state: phase index, period and high-time per channel.
    int         k0, k1, p0, h0, p1, h1;
    logic [1:0] on;

    function automatic void check(input string name, input int idx,
                                  input logic [5:0] act, input logic [5:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s #%0d: {out,tick,pend} got %b required %b at %0t",
                     name, idx, act, req, $time);
        end
    endfunction

    // Queue the expected outputs for the coming edge, then let that edge pass.
    task automatic push_exp(input logic [1:0] pend, input int tag);
        exp_t e;
        int   ph;
        e.out  = 2'b00;
        e.tick = 2'b00;
        if (on[0]) begin
            ph        = k0 % p0;
            e.tick[0] = (ph == 0);
            e.out[0]  = (ph < h0);
            k0++;
        end
        if (on[1]) begin
            ph        = k1 % p1;
            e.tick[1] = (ph == 0);
            e.out[1]  = (ph < h1);
            k1++;
        end
        e.pend = pend;
        e.tag  = tag;
        e.idx  = cyc_idx;
        cyc_idx++;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic [1:0] pend, input int tag);
        for (int i = 0; i < n; i++) begin
            push_exp(pend, tag);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare just after each edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check($sformatf("test%0d", mon_e.tag), mon_e.idx,
                  {out, tick, upd_pend}, {mon_e.out, mon_e.tick, mon_e.pend});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d entries queued", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        en         = 2'b00;
        sync_start = 1'b0;
        wr_en      = 1'b0;
        wr_ch      = '0;
        wr_div     = '0;
        wr_high    = '0;
        on         = 2'b00;
        k0 = 0; k1 = 0; p0 = 32; h0 = 16; p1 = 32; h1 = 16;

        @(negedge clk);
        run(2, 2'b00, 0);
        reset = 1'b0;
        run(2, 2'b00, 0);

        // 1: default divide-by-32, half duty, on channel 0 only.
        en = 2'b01; on = 2'b01; k0 = 0;
        run(64, 2'b00, 1);

        // 2: mid-period write to ch0 waits for the boundary, then 5/2.
        run(10, 2'b00, 2);
        wr_en = 1'b1; wr_ch = CH_W'(0); wr_div = 8'd5; wr_high = 8'd2;
        run(1, 2'b01, 2);
        wr_en = 1'b0;
        run(21, 2'b01, 2);
        p0 = 5; h0 = 2; k0 = 0;
        run(15, 2'b00, 2);

        // 3: ch1 divide-by-1, out-of-range channel, then divisor 0.
        wr_en = 1'b1; wr_ch = CH_W'(1); wr_div = 8'd1; wr_high = 8'd1;
        run(1, 2'b10, 3);
        wr_en = 1'b0;
        en = 2'b11; on = 2'b11; p1 = 1; h1 = 1; k1 = 0;
        run(6, 2'b00, 3);
        wr_en = 1'b1; wr_ch = CH_W'(2); wr_div = 8'd3; wr_high = 8'd0;
        run(1, 2'b00, 3);
        wr_en = 1'b0;
        run(2, 2'b00, 3);
        wr_en = 1'b1; wr_ch = CH_W'(1); wr_div = 8'd0; wr_high = 8'd0;
        run(1, 2'b10, 3);
        wr_en = 1'b0;
        on = 2'b01;
        run(5, 2'b00, 3);

        // 4: both channels 7/3 at different phases, then sync_start aligns them.
        while (k0 % 5 != 1) run(1, 2'b00, 4);
        wr_en = 1'b1; wr_ch = CH_W'(0); wr_div = 8'd7; wr_high = 8'd3;
        run(1, 2'b01, 4);
        wr_ch = CH_W'(1);
        run(1, 2'b11, 4);
        wr_en = 1'b0;
        on = 2'b11; p1 = 7; h1 = 3; k1 = 0;
        run(2, 2'b01, 4);
        p0 = 7; h0 = 3; k0 = 0;
        run(10, 2'b00, 4);
        sync_start = 1'b1; k0 = 0; k1 = 0;
        run(1, 2'b00, 4);
        sync_start = 1'b0;
        run(6, 2'b00, 4);
        sync_start = 1'b1;
        run(1, 2'b00, 4);
        sync_start = 1'b0;
        run(5, 2'b00, 4);

        // 5: write on ch0's boundary edge; old settings hold one more period.
        while (k0 % 7 != 0) run(1, 2'b00, 5);
        wr_en = 1'b1; wr_ch = CH_W'(0); wr_div = 8'd4; wr_high = 8'd1;
        run(1, 2'b01, 5);
        wr_en = 1'b0;
        run(6, 2'b01, 5);
        p0 = 4; h0 = 1; k0 = 0;
        run(8, 2'b00, 5);

        // 6: reset mid-period with a pending ch1 write; defaults come back.
        while (k1 % 7 == 0) run(1, 2'b00, 6);
        wr_en = 1'b1; wr_ch = CH_W'(1); wr_div = 8'd3; wr_high = 8'd3;
        run(1, 2'b10, 6);
        wr_en = 1'b0;
        reset = 1'b1;
        #1;
        check("test6_async_clear", 0, {out, tick, upd_pend}, 6'b000000);
        on = 2'b00;
        @(negedge clk);
        run(2, 2'b00, 6);
        reset = 1'b0;
        on = 2'b11; p0 = 32; h0 = 16; p1 = 32; h1 = 16; k0 = 0; k1 = 0;
        run(34, 2'b00, 6);

        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
